ps2_move_decoder: RTL
=====================

# ps2_move_decoder

PS/2 keyboard receiver and scan-code decoder for the snake game. Samples the raw `PS2C`/`PS2D` lines on the system clock, reassembles 11-bit PS/2 device-to-host frames, checks them, and turns arrow-key and WASD make codes into the 2-bit `move` direction consumed by `snake_game`. It sits between the board PS/2 pins and the game's direction input, and replaces the button-based direction logic.

## Interface

**Parameters**
- `FILTER_LEN`, default 8: consecutive identical samples required before a filtered `PS2C` level changes.
- `TIMEOUT`, default 10000: `mclk` cycles without a filtered falling edge mid-frame before the frame is aborted (200 µs at 50 MHz).

**Ports**
- `mclk`, input, 1: system clock, 50 MHz.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `ps2c`, input, 1: raw PS/2 clock, asynchronous to `mclk`.
- `ps2d`, input, 1: raw PS/2 data, asynchronous to `mclk`.
- `rx_byte`, output, 8: last correctly received byte.
- `rx_valid`, output, 1: one-cycle pulse; `rx_byte` updated.
- `rx_error`, output, 1: one-cycle pulse on a start, parity or stop error, or on timeout.
- `busy`, output, 1: high while a frame is in progress.
- `move`, output, 2: direction; right=0, up=1, left=2, down=3.
- `move_valid`, output, 1: one-cycle pulse; `move` updated.

## Operation

**Input conditioning**
- `ps2c` and `ps2d` each pass through a 2-flop synchronizer.
- `ps2c` then passes through a glitch filter. The filtered level flips only after `FILTER_LEN` equal consecutive samples.
- A falling edge is a filtered-level transition 1→0. It generates a one-cycle `fall` strobe.
- `ps2d` is sampled from the synchronized line on `fall`.

**Frame FSM**
- **IDLE**: on `fall` with data=0, go to RECV with bit count 0. On `fall` with data=1, stay in IDLE and raise no error (line noise).
- **RECV**: on each `fall`, shift data into the shift register LSB-first. Bits 0–7 are data, bit 8 is parity, bit 9 is stop. After the stop bit, go to IDLE.
  - If parity is odd over data+parity and stop=1, pulse `rx_valid` and load `rx_byte`.
  - Otherwise pulse `rx_error`; `rx_byte` is unchanged.
- **Timeout**: the idle counter clears on every `fall`. In RECV, when the counter reaches `TIMEOUT`, pulse `rx_error` and go to IDLE.
  - If `fall` and expiry occur in the same cycle, `fall` wins.
- `busy` = (state == RECV).

**Decoder**
- Two flags: `ext` (E0 seen) and `brk` (F0 seen).
- On `rx_valid`:
  - byte E0 sets `ext`.
  - byte F0 sets `brk`.
  - Any other byte is a key code: it is evaluated, then `ext` and `brk` clear.
- Key-code mapping, applied only when `brk`=0:
  - With `ext`=1: 75→up, 72→down, 6B→left, 74→right.
  - With `ext`=0: 1D (W)→up, 1B (S)→down, 1C (A)→left, 23 (D)→right.
- A match loads `move` and pulses `move_valid`. Non-matching codes and break codes are silently ignored.
- Repeated (typematic) make codes re-pulse `move_valid`.
- `rx_error` clears `ext` and `brk`.

**Reset**
- All outputs are 0; `move` = right (0).
- FSM is in IDLE, counters and flags are clear, filter level is 1.
- Reset mid-frame discards the partial frame. The next frame is accepted only from a fresh start bit.

## Timing

- Filtered edge lags the pin by 2 + `FILTER_LEN` cycles.
- `rx_valid`/`rx_error` assert in the cycle after the `fall` of the stop bit.
- `move_valid` asserts 1 cycle after `rx_valid`, and `move` changes in that same cycle.
- `move` holds its value between pulses.
- `rx_valid` and `rx_error` are mutually exclusive in any cycle.
- Minimum spacing between `rx_valid` pulses is one PS/2 frame (about 0.6 ms or more).
- All state is on `mclk`. There are no derived clocks.

## Structure

- Shared package `snake_pkg` holds:
  - direction constants RIGHT/UP/LEFT/DOWN = 0/1/2/3, also used by `snake_game`;
  - scan-code constants: SC_EXT=E0, SC_BRK=F0, and the eight key codes.
- Sub-module `ps2_rx` contains the synchronizers, filter, frame FSM and timeout, and drives `rx_byte`, `rx_valid`, `rx_error` and `busy`.
- The top of this block holds the decoder flags and the `move` register.

## Test plan

The bench drives an ideal PS/2 device at 12.5 kHz; all defaults apply.

- Frame 1D with correct parity → `rx_valid` with `rx_byte`=1D, then `move_valid` the next cycle with `move`=1.
- Frames E0, 74 → `move`=0 with one `move_valid`; E0 alone produces no `move_valid`.
- Frames E0, F0, 6B → three `rx_valid` pulses, no `move_valid`, `move` unchanged; the following 1C → `move`=2.
- Frame 1B with parity flipped → `rx_error` pulse, no `rx_valid`, `move` unchanged. Also stop=0 → `rx_error`.
- Five bits, then silence for 250 µs → `rx_error` at `TIMEOUT`, `busy` drops. The next clean 72-after-E0 sequence → `move`=3.
- `reset_n` low mid-frame → outputs 0 and `move`=0. The tail bits after release produce no `rx_valid`, and the next full frame decodes correctly.
- 1-cycle glitches on `ps2c` (length < `FILTER_LEN`) → no extra bits, and the frame decodes correctly.

Source files
------------

// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snake_pkg
// Purpose  : Shared directions, PS/2 scan codes and key-map helper for the
//            snake game and its PS/2 direction decoder.
// Revision : 1.0 - initial release
// ============================================================================
package snake_pkg;

    // Directions, shared with snake_game
    localparam logic [1:0] RIGHT = 2'd0;
    localparam logic [1:0] UP    = 2'd1;
    localparam logic [1:0] LEFT  = 2'd2;
    localparam logic [1:0] DOWN  = 2'd3;

    // Scan-code prefixes
    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    // Extended (E0-prefixed) arrow keys
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // Plain WASD keys
    localparam logic [7:0] SC_W = 8'h1D;
    localparam logic [7:0] SC_S = 8'h1B;
    localparam logic [7:0] SC_A = 8'h1C;
    localparam logic [7:0] SC_D = 8'h23;

    // Index of the stop bit counting from the first data bit
    localparam logic [3:0] c_frame_last = 4'd9;

    typedef struct packed {
        logic       hit;
        logic [1:0] dir;
    } key_map_t;

    // Translate a make code into a direction; hit=0 means "not a movement key"
    function automatic key_map_t map_key(input logic ext, input logic [7:0] code);
        key_map_t m;
        m.hit = 1'b1;
        m.dir = RIGHT;
        if (ext) begin
            case (code)
                SC_UP:    m.dir = UP;
                SC_DOWN:  m.dir = DOWN;
                SC_LEFT:  m.dir = LEFT;
                SC_RIGHT: m.dir = RIGHT;
                default:  m.hit = 1'b0;
            endcase
        end else begin
            case (code)
                SC_W:    m.dir = UP;
                SC_S:    m.dir = DOWN;
                SC_A:    m.dir = LEFT;
                SC_D:    m.dir = RIGHT;
                default: m.hit = 1'b0;
            endcase
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx
// Purpose  : PS/2 device-to-host receiver: synchronizers, PS2C glitch
//            filter, 11-bit frame FSM with parity/stop check and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_rx
    import snake_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 10000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_ps2c,
    input  logic       i_ps2d,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_valid,
    output logic       o_rx_error,
    output logic       o_busy
);

    localparam int c_filt_w = $clog2(FILTER_LEN + 1);
    localparam int c_tmr_w  = $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RECV = 1'b1
    } state_t;

    logic [1:0]          r_c_sync;
    logic [1:0]          r_d_sync;
    logic                r_filt_level;
    logic [c_filt_w-1:0] r_filt_cnt;
    logic                r_fall;
    state_t              r_state;
    logic [3:0]          r_bit_cnt;
    logic [8:0]          r_shift;
    logic [c_tmr_w-1:0]  r_timer;

    logic       w_filt_flip;
    logic [9:0] w_frame;
    logic       w_frame_ok;

    // A flip needs FILTER_LEN consecutive samples disagreeing with the level
    assign w_filt_flip = (r_c_sync[1] != r_filt_level) &&
                         (r_filt_cnt == c_filt_w'(FILTER_LEN - 1));

    // Frame as it stands once the current data sample is shifted in
    assign w_frame    = {r_d_sync[1], r_shift};
    assign w_frame_ok = (^w_frame[8:0]) && w_frame[9];

    assign o_busy = (r_state == S_RECV);

    // Two-flop synchronizers; lines idle high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c_sync <= 2'b11;
            r_d_sync <= 2'b11;
        end else begin
            r_c_sync <= {r_c_sync[0], i_ps2c};
            r_d_sync <= {r_d_sync[0], i_ps2d};
        end
    end

    // Glitch filter on PS2C and one-cycle falling-edge strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt_level <= 1'b1;
            r_filt_cnt   <= '0;
            r_fall       <= 1'b0;
        end else begin
            r_fall <= w_filt_flip && r_filt_level;
            if (r_c_sync[1] == r_filt_level) begin
                r_filt_cnt <= '0;
            end else if (w_filt_flip) begin
                r_filt_level <= ~r_filt_level;
                r_filt_cnt   <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    // Frame FSM: start detection, bit assembly, check and timeout abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_timer    <= '0;
            o_rx_byte  <= '0;
            o_rx_valid <= 1'b0;
            o_rx_error <= 1'b0;
        end else begin
            o_rx_valid <= 1'b0;
            o_rx_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    // A high start bit is line noise and is dropped silently
                    if (r_fall && !r_d_sync[1]) begin
                        r_state   <= S_RECV;
                        r_bit_cnt <= '0;
                    end
                end
                S_RECV: begin
                    // A falling edge takes priority over an expiring timer
                    if (r_fall) begin
                        r_timer <= '0;
                        r_shift <= w_frame[9:1];
                        if (r_bit_cnt == c_frame_last) begin
                            r_state <= S_IDLE;
                            if (w_frame_ok) begin
                                o_rx_valid <= 1'b1;
                                o_rx_byte  <= w_frame[7:0];
                            end else begin
                                o_rx_error <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else if (r_timer == c_tmr_w'(TIMEOUT - 1)) begin
                        o_rx_error <= 1'b1;
                        r_state    <= S_IDLE;
                        r_timer    <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_move_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_move_decoder
// Purpose  : PS/2 keyboard to snake direction decoder. Tracks E0/F0
//            prefixes and maps arrow / WASD make codes onto move.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_move_decoder
    import snake_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 10000
) (
    input  logic       mclk,
    input  logic       reset_n,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_error,
    output logic       busy,
    output logic [1:0] move,
    output logic       move_valid
);

    logic     r_ext;
    logic     r_brk;
    key_map_t w_key;

    ps2_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) u_ps2_rx (
        .clk        (mclk),
        .rst_n      (reset_n),
        .i_ps2c     (ps2c),
        .i_ps2d     (ps2d),
        .o_rx_byte  (rx_byte),
        .o_rx_valid (rx_valid),
        .o_rx_error (rx_error),
        .o_busy     (busy)
    );

    assign w_key = map_key(r_ext, rx_byte);

    // Prefix tracking and direction register; break codes never move
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_ext      <= 1'b0;
            r_brk      <= 1'b0;
            move       <= RIGHT;
            move_valid <= 1'b0;
        end else begin
            move_valid <= 1'b0;
            if (rx_error) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (rx_valid) begin
                if (rx_byte == SC_EXT) begin
                    r_ext <= 1'b1;
                end else if (rx_byte == SC_BRK) begin
                    r_brk <= 1'b1;
                end else begin
                    if (!r_brk && w_key.hit) begin
                        move       <= w_key.dir;
                        move_valid <= 1'b1;
                    end
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire
